// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Two-master / one-slave AXI4-lite arbiter. The instruction-fetch master (I)
// issues reads only; the load/store master (D) issues reads and writes. One
// transaction is granted at a time, round-robin between the masters, and the
// slave's responses are routed back to the owner. A response watchdog answers
// a hung transaction with SLVERR.
//
// Ports:
//   clk, rstn               clock, synchronous active-low reset
//   i_ar*, i_r*             I master read-address / read-data channels
//   d_ar*, d_r*             D master read-address / read-data channels
//   d_aw*, d_w*, d_b*       D master write-address / write-data / response
//   m_ar*, m_r*             slave read-address / read-data channels
//   m_aw*, m_w*, m_b*       slave write-address / write-data / response
//   grant                   current owner: 00 none, 01 I, 10 D (registered)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rstn,
   // I master
   input  logic [ADDR_W-1:0]   i_araddr,
   input  logic                i_arvalid,
   output logic                i_arready,
   output logic [DATA_W-1:0]   i_rdata,
   output logic [1:0]          i_rresp,
   output logic                i_rvalid,
   input  logic                i_rready,
   // D master
   input  logic [ADDR_W-1:0]   d_araddr,
   input  logic                d_arvalid,
   output logic                d_arready,
   output logic [DATA_W-1:0]   d_rdata,
   output logic [1:0]          d_rresp,
   output logic                d_rvalid,
   input  logic                d_rready,
   input  logic [ADDR_W-1:0]   d_awaddr,
   input  logic                d_awvalid,
   output logic                d_awready,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   input  logic                d_wvalid,
   output logic                d_wready,
   output logic [1:0]          d_bresp,
   output logic                d_bvalid,
   input  logic                d_bready,
   // slave
   output logic [ADDR_W-1:0]   m_araddr,
   output logic                m_arvalid,
   input  logic                m_arready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rvalid,
   output logic                m_rready,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready,
   // owner
   output logic [1:0]          grant
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_I    = 2'b01;
   localparam logic [1:0] GRANT_D    = 2'b10;
   localparam logic [1:0] RESP_SLV   = 2'b10;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      I_RD = 3'd1,
      D_RD = 3'd2,
      D_WR = 3'd3,
      ERR  = 3'd4
   } state_t;

   state_t            state, state_next;
   logic [1:0]        grant_next;
   logic              last_d, last_d_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   // remembers whether the granted D transaction was a write, so ERR knows
   // which response channel to answer on
   logic              err_wr, err_wr_next;

   logic              req_i;
   logic              req_d;
   logic              expire;

   assign req_i  = i_arvalid;
   assign req_d  = d_arvalid | d_awvalid;
   assign expire = (cnt == CNT_W'(TIMEOUT - 1));

   // State, grant, fairness flag and watchdog registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= IDLE;
         grant  <= GRANT_NONE;
         last_d <= 1'b0;
         cnt    <= '0;
         err_wr <= 1'b0;
      end else begin
         state  <= state_next;
         grant  <= grant_next;
         last_d <= last_d_next;
         cnt    <= cnt_next;
         err_wr <= err_wr_next;
      end
   end

   // Arbitration, completion/watchdog next-state and channel forwarding
   always_comb begin
      state_next  = state;
      grant_next  = grant;
      last_d_next = last_d;
      cnt_next    = cnt;
      err_wr_next = err_wr;

      i_arready = 1'b0;
      i_rdata   = '0;
      i_rresp   = 2'b00;
      i_rvalid  = 1'b0;
      d_arready = 1'b0;
      d_rdata   = '0;
      d_rresp   = 2'b00;
      d_rvalid  = 1'b0;
      d_awready = 1'b0;
      d_wready  = 1'b0;
      d_bresp   = 2'b00;
      d_bvalid  = 1'b0;
      m_araddr  = '0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      m_awaddr  = '0;
      m_awvalid = 1'b0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;

      case (state)
         IDLE: begin
            // accept and drop any late slave response
            m_rready = 1'b1;
            m_bready = 1'b1;
            cnt_next = '0;
            // I wins a collision only if D had the previous grant
            if (req_i && (!req_d || last_d)) begin
               state_next  = I_RD;
               grant_next  = GRANT_I;
               last_d_next = 1'b0;
               err_wr_next = 1'b0;
            end else if (req_d) begin
               state_next  = d_arvalid ? D_RD : D_WR;
               grant_next  = GRANT_D;
               last_d_next = 1'b1;
               err_wr_next = !d_arvalid;
            end else begin
               state_next = IDLE;
            end
         end

         I_RD: begin
            m_araddr  = i_araddr;
            m_arvalid = i_arvalid;
            i_arready = m_arready;
            i_rdata   = m_rdata;
            i_rresp   = m_rresp;
            i_rvalid  = m_rvalid;
            m_rready  = i_rready;
            if (m_rvalid && i_rready) begin
               state_next = IDLE;
               grant_next = GRANT_NONE;
            end else if (expire) begin
               state_next = ERR;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         D_RD: begin
            m_araddr  = d_araddr;
            m_arvalid = d_arvalid;
            d_arready = m_arready;
            d_rdata   = m_rdata;
            d_rresp   = m_rresp;
            d_rvalid  = m_rvalid;
            m_rready  = d_rready;
            if (m_rvalid && d_rready) begin
               state_next = IDLE;
               grant_next = GRANT_NONE;
            end else if (expire) begin
               state_next = ERR;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         D_WR: begin
            // AW and W forwarded independently; either may complete first
            m_awaddr  = d_awaddr;
            m_awvalid = d_awvalid;
            d_awready = m_awready;
            m_wdata   = d_wdata;
            m_wstrb   = d_wstrb;
            m_wvalid  = d_wvalid;
            d_wready  = m_wready;
            d_bresp   = m_bresp;
            d_bvalid  = m_bvalid;
            m_bready  = d_bready;
            if (m_bvalid && d_bready) begin
               state_next = IDLE;
               grant_next = GRANT_NONE;
            end else if (expire) begin
               state_next = ERR;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         ERR: begin
            // arbiter answers the owner itself; slave side stays quiet
            if (err_wr) begin
               d_bvalid = 1'b1;
               d_bresp  = RESP_SLV;
               if (d_bready) begin
                  state_next = IDLE;
                  grant_next = GRANT_NONE;
               end else begin
                  state_next = ERR;
               end
            end else if (grant == GRANT_I) begin
               i_rvalid = 1'b1;
               i_rresp  = RESP_SLV;
               if (i_rready) begin
                  state_next = IDLE;
                  grant_next = GRANT_NONE;
               end else begin
                  state_next = ERR;
               end
            end else begin
               d_rvalid = 1'b1;
               d_rresp  = RESP_SLV;
               if (d_rready) begin
                  state_next = IDLE;
                  grant_next = GRANT_NONE;
               end else begin
                  state_next = ERR;
               end
            end
         end

         default: begin
            state_next = IDLE;
            grant_next = GRANT_NONE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave AXI4-lite arbiter sharing the memory bus between the instruction-fetch master (I, read-only) and the load/store master (D, read and write).
- Grants one transaction at a time, round-robin between masters, and routes the slave's responses back to the granted master.
- Exports `grant` so downstream slaves (SRAM, UART decode) know the current owner.
- Contains a response watchdog that answers a hung transaction with SLVERR.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- TIMEOUT, 255, cycles from grant without a response before an error is returned; must be ≥2.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- i_araddr/i_arvalid/i_arready  in/in/out  ADDR_W/1/1  I read-address channel.
- i_rdata/i_rresp/i_rvalid/i_rready  out/out/out/in  DATA_W/2/1/1  I read-data channel.
- d_araddr/d_arvalid/d_arready  in/in/out  ADDR_W/1/1  D read-address channel.
- d_rdata/d_rresp/d_rvalid/d_rready  out/out/out/in  DATA_W/2/1/1  D read-data channel.
- d_awaddr/d_awvalid/d_awready  in/in/out  ADDR_W/1/1  D write-address channel.
- d_wdata/d_wstrb/d_wvalid/d_wready  in/in/in/out  DATA_W/DATA_W/8/1/1  D write-data channel.
- d_bresp/d_bvalid/d_bready  out/out/in  2/1/1  D write-response channel.
- m_araddr/m_arvalid/m_arready  out/out/in  ADDR_W/1/1  slave read-address channel.
- m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  DATA_W/2/1/1  slave read-data channel.
- m_awaddr/m_awvalid/m_awready  out/out/in  ADDR_W/1/1  slave write-address channel.
- m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  DATA_W/DATA_W/8/1/1  slave write-data channel.
- m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  slave write-response channel.
- grant  out  2  owner: 2'b00 none, 2'b01 I, 2'b10 D.

Behaviour:
- Clock and reset: clk, rstn synchronous active-low.
- Reset state:
  - state=IDLE, grant=00, last_d=0, timeout counter=0.
  - All master-side valids/readies and all slave-side valids are 0; m_rready=m_bready=1.
- States: IDLE, I_RD, D_RD, D_WR, ERR.
- IDLE arbitration, evaluated each cycle on the request signals:
  - Request I = i_arvalid; request D = d_arvalid | d_awvalid.
  - Only one requests: grant it.
  - Both request: grant I if last_d=1, else D.
  - Within D: d_arvalid beats d_awvalid, giving D_RD.
- Transition timing:
  - Transition and grant update occur on the next edge; grant is registered.
  - last_d is updated on entry: D_RD/D_WR set it to 1, I_RD clears it.
- Forwarding in I_RD, D_RD, D_WR: purely combinational between the granted master and the slave.
  - Address, data, strobe, valid and ready are forwarded; resp/rdata are forwarded.
  - Channels not belonging to the granted transaction are held at 0 on both sides.
  - In D_WR, AW and W are forwarded independently and may complete in either order.
- Completion:
  - I_RD/D_RD exit on m_rvalid&m_rready; D_WR exits on m_bvalid&m_bready. The exit goes to IDLE.
  - Minimum one IDLE cycle between transactions: the request is visible in cycle N, forwarding starts in N+1, and the earliest next grant comes 2 cycles after the response handshake.
- Watchdog:
  - The counter clears on entry to any grant state and increments each cycle in it.
  - When counter==TIMEOUT-1 and no completing handshake occurs in that cycle, go to ERR. All m_* valids drop to 0.
  - In ERR, the arbiter itself drives the granted master's response channel: rvalid or bvalid=1, resp=2'b10, rdata=0. It holds these until the master's ready, then goes to IDLE.
  - A handshake in the same cycle as expiry wins: normal completion, no ERR.
- Late slave responses:
  - m_rready/m_bready=1 in IDLE only, so late slave responses are drained.
  - A slave response arriving after a new grant is a system error and is out of scope.
- Request stability: masters must hold valid and payload stable until their handshake; the arbiter does not latch payloads.
- Reset mid-transaction: on rstn=0 the arbiter returns to the reset state in one cycle regardless of state. Any partial transaction is abandoned.
- Grant holds its value through ERR.

Test Plan:
- Only I requests, addr 0x8000_0000; slave responds rdata 0xDEAD_BEEF after 3 cycles -> grant=01 from cycle 1; i_rdata=0xDEAD_BEEF, i_rresp=0; grant=00 the cycle after the handshake.
- I and D both assert arvalid in the same IDLE cycle, from reset -> D granted first (grant=10), then I; a repeated collision alternates I, D, I.
- D write with awvalid 2 cycles before wvalid, wdata 0x1234_5678, wstrb 4'b0011 -> m_aw* and m_w* forwarded independently; d_bresp=0; exit on the b handshake.
- D asserts arvalid and awvalid together -> read completes first, then IDLE, then write granted.
- Slave never responds, TIMEOUT=8 -> ERR entered 8 cycles after grant; d_rresp=2'b10 and d_rdata=0 until d_rready; then IDLE.
- rstn=0 during D_WR with wvalid high -> next cycle grant=00, all valids 0, m_rready=m_bready=1.
